// File: rtl/jdec_pkg.sv
// jdec_pkg: shared types and constants for the Johnson phase decoder.
//   state_e : decoder state (HUNT, LOCKED)
//   cls_e   : classification of one sampled code
//   ERRCNT_W: width of the saturating error counter
//   jc_code : Johnson code word of phase k for an n-bit code
package jdec_pkg;
  localparam int ERRCNT_W = 8;
  typedef enum logic {HUNT, LOCKED} state_e;
  typedef enum logic [2:0] {CLS_ILLEGAL, CLS_FIRST, CLS_HOLD, CLS_STEP, CLS_SKIP} cls_e;
  // Phases 0..n fill ones from the bottom; phases n+1..2n-1 drain them from the bottom.
  function automatic logic [31:0] jc_code(input int n, input int k);
    logic [31:0] all_ones;
    all_ones = (32'd1 << n) - 32'd1;
    return k <= n ? (32'd1 << k) - 32'd1 : all_ones & ~((32'd1 << (k - n)) - 32'd1);
  endfunction
endpackage

// File: rtl/johnson_code_classify.sv
// johnson_code_classify: combinational decode of one Johnson code word.
//   code  : N-bit input code
//   legal : code is one of the 2N Johnson phases
//   idx   : phase index of code (0 when illegal)
//   succ  : successor code {code[N-2:0], ~code[N-1]}
module johnson_code_classify import jdec_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0]             code,
  output logic                     legal,
  output logic [$clog2(2*N)-1:0]   idx,
  output logic [N-1:0]             succ
);
  localparam int IW = $clog2(2*N);
  always_comb begin
    legal = 1'b0;
    idx = '0;
    for (int k = 0; k < 2*N; k++) begin
      if (code == N'(jc_code(N, k))) begin
        legal = 1'b1;
        idx = IW'(k);
      end
    end
  end
  assign succ = {code[N-2:0], ~code[N-1]};
endmodule

// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder: registered phase decode and lock tracking of a Johnson counter.
//   clk, rst (async, active-high), en (sample enable), in_code (N-bit code)
//   phase_valid, phase_idx, phase_onehot : decode of the last sample
//   locked     : sequence has stepped correctly LOCK_THRESH times
//   err_pulse  : illegal code, or skip while locked
//   wrap_pulse : step from phase 2N-1 to 0 while locked
//   err_count  : saturating error count, only when JDEC_ERRCNT_EN is defined (else 0)
module johnson_phase_decoder import jdec_pkg::*; #(
  parameter int N           = 4,
  parameter int LOCK_THRESH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N-1:0]            in_code,
  output logic                    phase_valid,
  output logic [$clog2(2*N)-1:0]  phase_idx,
  output logic [2*N-1:0]          phase_onehot,
  output logic                    locked,
  output logic                    err_pulse,
  output logic                    wrap_pulse,
  output logic [ERRCNT_W-1:0]     err_count
);
  localparam int IW = $clog2(2*N);
  localparam int P = 2*N;
  logic          legal;
  logic [IW-1:0] idx;
  logic [N-1:0]  succ;
  cls_e          cls;
  logic [3:0]    cnt_inc;
  logic          lock_now;
  state_e        state_q, state_d;
  logic [3:0]    good_cnt_q, good_cnt_d;
  logic          first_q, first_d;
  logic [N-1:0]  prev_code_q, prev_code_d;
  logic [N-1:0]  succ_q, succ_d;
  logic          phase_valid_q, phase_valid_d;
  logic [IW-1:0] phase_idx_q, phase_idx_d;
  logic [P-1:0]  phase_onehot_q, phase_onehot_d;
  logic          locked_q, locked_d;
  logic          err_q, err_d;
  logic          wrap_q, wrap_d;
  johnson_code_classify #(.N(N)) u_cls (
    .code  (in_code),
    .legal (legal),
    .idx   (idx),
    .succ  (succ)
  );
  // succ_q caches the successor of prev_code so STEP is a plain compare.
  assign cls = !legal ? CLS_ILLEGAL :
               first_q ? CLS_FIRST :
               in_code == prev_code_q ? CLS_HOLD :
               in_code == succ_q ? CLS_STEP : CLS_SKIP;
  assign cnt_inc = good_cnt_q + 4'd1;
  assign lock_now = state_q == HUNT && cls == CLS_STEP && int'(cnt_inc) >= LOCK_THRESH;
  always_comb begin
    state_d = state_q;
    good_cnt_d = good_cnt_q;
    first_d = first_q;
    prev_code_d = prev_code_q;
    succ_d = succ_q;
    phase_valid_d = phase_valid_q;
    phase_idx_d = phase_idx_q;
    phase_onehot_d = phase_onehot_q;
    locked_d = locked_q;
    err_d = 1'b0;
    wrap_d = 1'b0;
    if (en) begin
      first_d = cls == CLS_ILLEGAL;
      prev_code_d = legal ? in_code : prev_code_q;
      succ_d = legal ? succ : succ_q;
      phase_valid_d = legal;
      phase_idx_d = legal ? idx : phase_idx_q;
      phase_onehot_d = legal ? {{(P-1){1'b0}}, 1'b1} << idx : '0;
      err_d = cls == CLS_ILLEGAL || (state_q == LOCKED && cls == CLS_SKIP);
      wrap_d = state_q == LOCKED && cls == CLS_STEP && idx == '0;
      state_d = (cls == CLS_ILLEGAL || cls == CLS_SKIP) ? HUNT : lock_now ? LOCKED : state_q;
      good_cnt_d = (cls == CLS_ILLEGAL || cls == CLS_SKIP || lock_now || state_q == LOCKED) ? 4'd0 :
                   cls == CLS_STEP ? cnt_inc : good_cnt_q;
      locked_d = state_d == LOCKED;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      good_cnt_q <= '0;
      first_q <= 1'b1;
      prev_code_q <= '0;
      succ_q <= '0;
      phase_valid_q <= 1'b0;
      phase_idx_q <= '0;
      phase_onehot_q <= '0;
      locked_q <= 1'b0;
      err_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      good_cnt_q <= good_cnt_d;
      first_q <= first_d;
      prev_code_q <= prev_code_d;
      succ_q <= succ_d;
      phase_valid_q <= phase_valid_d;
      phase_idx_q <= phase_idx_d;
      phase_onehot_q <= phase_onehot_d;
      locked_q <= locked_d;
      err_q <= err_d;
      wrap_q <= wrap_d;
    end
  end
`ifdef JDEC_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  // Count in the same edge as the pulse so err_count already includes it.
  always_comb err_cnt_d = (err_d && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= '0;
    else err_cnt_q <= err_cnt_d;
  end
  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif
  assign phase_valid = phase_valid_q;
  assign phase_idx = phase_idx_q;
  assign phase_onehot = phase_onehot_q;
  assign locked = locked_q;
  assign err_pulse = err_q;
  assign wrap_pulse = wrap_q;
endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb_johnson_phase_decoder: randomized self-checking bench against an index-level reference model.
module tb_johnson_phase_decoder;
  localparam int N = 4;
  localparam int P = 2*N;
  localparam int LT = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic [N-1:0] in_code = '0;
  logic phase_valid;
  logic [2:0] phase_idx;
  logic [P-1:0] phase_onehot;
  logic locked, err_pulse, wrap_pulse;
  logic [7:0] err_count;
  int n_vec = 0;
  int n_bad = 0;
  logic [N-1:0] codes [P];
  bit m_first, m_locked, m_valid, m_err, m_wrap;
  int m_prev, m_good, m_idx, m_errcnt;
  johnson_phase_decoder #(.N(N), .LOCK_THRESH(LT)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .in_code      (in_code),
    .phase_valid  (phase_valid),
    .phase_idx    (phase_idx),
    .phase_onehot (phase_onehot),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .wrap_pulse   (wrap_pulse),
    .err_count    (err_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int lookup(input logic [N-1:0] c);
    for (int k = 0; k < P; k++) if (codes[k] == c) return k;
    return -1;
  endfunction
  task automatic mdl_reset();
    m_first = 1; m_locked = 0; m_valid = 0; m_err = 0; m_wrap = 0;
    m_prev = 0; m_good = 0; m_idx = 0; m_errcnt = 0;
  endtask
  task automatic mdl_step(input bit e, input logic [N-1:0] c);
    int k;
    m_err = 0;
    m_wrap = 0;
    if (!e) return;
    k = lookup(c);
    if (k < 0) begin
      m_err = 1; m_locked = 0; m_good = 0; m_first = 1; m_valid = 0;
    end else begin
      m_valid = 1;
      m_idx = k;
      if (m_first) m_first = 0;
      else if (k == m_prev) begin
      end else if (k == (m_prev + 1) % P) begin
        if (m_locked) m_wrap = (k == 0);
        else begin
          m_good++;
          if (m_good >= LT) begin m_locked = 1; m_good = 0; end
        end
      end else begin
        m_err = m_locked;
        m_locked = 0;
        m_good = 0;
      end
      m_prev = k;
    end
`ifdef JDEC_ERRCNT_EN
    if (m_err && m_errcnt < 255) m_errcnt++;
`endif
  endtask
  task automatic check_all(input string tag);
    check({tag, ".valid"}, 32'(phase_valid), 32'(m_valid));
    check({tag, ".idx"}, 32'(phase_idx), 32'(m_idx));
    check({tag, ".onehot"}, 32'(phase_onehot), m_valid ? 32'(1) << m_idx : 32'd0);
    check({tag, ".locked"}, 32'(locked), 32'(m_locked));
    check({tag, ".err"}, 32'(err_pulse), 32'(m_err));
    check({tag, ".wrap"}, 32'(wrap_pulse), 32'(m_wrap));
    check({tag, ".errcnt"}, 32'(err_count), 32'(m_errcnt));
  endtask
  task automatic apply(input bit e, input logic [N-1:0] c, input string tag);
    en = e;
    in_code = c;
    @(posedge clk);
    mdl_step(e, c);
    #1;
    check_all(tag);
  endtask
  initial begin
    logic [N-1:0] c;
    codes[0] = '0;
    for (int k = 1; k < P; k++) codes[k] = {codes[k-1][N-2:0], ~codes[k-1][N-1]};
    mdl_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;
    apply(1, 4'b0000, "r34a");
    apply(1, 4'b0001, "r34b");
    apply(1, 4'b0011, "r34c");
    check("r34_lock", 32'(locked), 32'd1);
    check("r34_idx", 32'(phase_idx), 32'd2);
    check("r34_onehot", 32'(phase_onehot), 32'h04);
    apply(1, 4'b0111, "r35a");
    apply(1, 4'b0101, "r35b");
    check("r35_err", 32'(err_pulse), 32'd1);
    check("r35_valid", 32'(phase_valid), 32'd0);
    check("r35_idx_hold", 32'(phase_idx), 32'd3);
    apply(1, 4'b0000, "r36a");
    apply(1, 4'b0001, "r36b");
    apply(1, 4'b0011, "r36c");
    apply(1, 4'b1111, "r36d");
    check("r36_skip_err", 32'(err_pulse), 32'd1);
    check("r36_unlock", 32'(locked), 32'd0);
    apply(1, 4'b1110, "r36e");
    apply(1, 4'b1100, "r36f");
    check("r36_relock", 32'(locked), 32'd1);
    check("r36_idx", 32'(phase_idx), 32'd6);
    apply(1, 4'b1000, "r37a");
    apply(1, 4'b0000, "r37b");
    check("r37_wrap", 32'(wrap_pulse), 32'd1);
    apply(1, 4'b0001, "r37c");
    check("r37_wrap_once", 32'(wrap_pulse), 32'd0);
    apply(1, 4'b0011, "r38a");
    repeat (3) apply(1, 4'b0111, "r38b");
    repeat (3) apply(0, 4'b0101, "r38c");
    check("r38_locked", 32'(locked), 32'd1);
    check("r38_idx", 32'(phase_idx), 32'd3);
    #3 rst = 1'b1;
    #1;
    mdl_reset();
    check_all("async_rst");
    rst = 1'b0;
    apply(1, 4'b1100, "after_rst_first");
    check("r29_no_err", 32'(err_pulse), 32'd0);
    repeat (300) apply(1, 4'b0101, "illegal_run");
`ifdef JDEC_ERRCNT_EN
    check("r39_sat", 32'(err_count), 32'd255);
`else
    check("r39_off", 32'(err_count), 32'd0);
`endif
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 19);
      c = r < 12 ? codes[(m_prev + 1) % P] :
          r < 15 ? codes[m_prev] :
          r < 17 ? codes[$urandom_range(0, P-1)] : N'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        mdl_reset();
      end
      apply($urandom_range(0, 7) != 0, c, "rand");
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 Parameter N, default 4: Johnson code width; legal range 2..16; 2N phases.
REQ-002 Parameter LOCK_THRESH, default 2: consecutive successor transitions required to lock; range 1..15.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  sample enable; 0 = all state holds, pulse outputs low.
REQ-006 in_code  input  N  Johnson code from upstream johnson_counter out.
REQ-007 phase_valid  output  1  registered; last sample was a legal code.
REQ-008 phase_idx  output  clog2(2N)  registered phase index 0..2N-1.
REQ-009 phase_onehot  output  2N  registered one-hot of phase_idx; all-zero when phase_valid=0.
REQ-010 locked  output  1  registered; decoder tracking a correct sequence.
REQ-011 err_pulse  output  1  one-cycle pulse on any detected error.
REQ-012 wrap_pulse  output  1  one-cycle pulse on phase 2N-1 -> 0 while locked.
REQ-013 err_count  output  8  saturating error count (see Configuration).

Function
REQ-014 Code map: index k in 0..N = lower k bits set, rest clear; k in N+1..2N-1 = upper 2N-k bits set, rest clear (N=4: 0000=0, 0001=1, 0011=2, 0111=3, 1111=4, 1110=5, 1100=6, 1000=7).
REQ-015 Any other in_code is illegal.
REQ-016 Successor of code c is {c[N-2:0], ~c[N-1]}; index (k+1) mod 2N.
REQ-017 Latency: outputs reflect in_code sampled at the previous rising edge with en=1 (one register stage).
REQ-018 Decoder keeps prev_code plus first flag; first flag set by reset and by any illegal sample.
REQ-019 Sample classes: ILLEGAL; FIRST (legal, first flag set); HOLD (equals prev_code); STEP (equals successor of prev_code); SKIP (legal, none of the above).
REQ-020 States: HUNT, LOCKED; reset enters HUNT with good_cnt=0.
REQ-021 HUNT: STEP increments good_cnt; good_cnt reaching LOCK_THRESH -> LOCKED, locked=1 in the same output cycle as that sample.
REQ-022 HUNT: HOLD and FIRST keep good_cnt; SKIP clears good_cnt, no err_pulse; ILLEGAL clears good_cnt, err_pulse=1.
REQ-023 LOCKED: STEP and HOLD stay LOCKED, no error.
REQ-024 LOCKED: SKIP or ILLEGAL -> HUNT, good_cnt=0, locked=0, err_pulse=1 in that output cycle.
REQ-025 wrap_pulse=1 only for a STEP from index 2N-1 to 0 while LOCKED both before and after.
REQ-026 ILLEGAL sample: phase_valid=0, phase_onehot=0, phase_idx holds previous value.
REQ-027 en=0: prev_code, state, counters, phase outputs hold; err_pulse=0, wrap_pulse=0.

Reset
REQ-028 rst=1 immediately forces: state HUNT, good_cnt 0, first flag 1, phase_valid 0, phase_idx 0, phase_onehot 0, locked 0, err_pulse 0, wrap_pulse 0, err_count 0.
REQ-029 Reset asserted mid-sequence discards history; first legal sample after release is FIRST, never SKIP.

Configuration
REQ-030 Macro JDEC_ERRCNT_EN defined: err_count increments on each err_pulse, saturates at 255, cleared only by rst.
REQ-031 Macro JDEC_ERRCNT_EN undefined: no counter logic; err_count tied to 0; all other behaviour identical.

Structure
REQ-032 Shared package jdec_pkg holds state typedef (HUNT, LOCKED), sample-class typedef, and ERRCNT_W=8 constant.
REQ-033 One combinational sub-module johnson_code_classify (in code -> legal flag, index, successor code); everything else in the top.

Verification
REQ-034 N=4: reset, then in_code 0000,0001,0011 on successive edges -> locked=1 with phase_idx=2; phase_onehot=00000100.
REQ-035 Locked at index 3, in_code=0101 -> err_pulse one cycle, phase_valid=0, locked=0, err_count=1 (macro on).
REQ-036 Locked at 0011, next in_code=1111 (SKIP) -> err_pulse, locked=0; then 1110,1100 -> relock at phase_idx=6.
REQ-037 Locked, 1000 -> 0000 -> wrap_pulse=1 one cycle, phase_idx 7 -> 0, locked stays 1.
REQ-038 Locked, in_code held 0111 for 3 cycles, then en=0 with in_code=0101 -> no err_pulse, locked=1, phase_idx=3 throughout.
REQ-039 rst pulsed asynchronously mid-cycle while locked -> all outputs zero before next edge; 300 illegal samples -> err_count=255 (macro on), 0 (macro off).
